// File: rtl/fifo_rr_wr_arbiter_if.sv
// Handshake bundle between NUM_REQ producers, the round-robin write arbiter and the FIFO write port.
// The master modport is the arbiter's view; the slave modport is the producer/FIFO environment's view.
interface fifo_rr_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 8
);
   localparam int SRC_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      fifo_out_valid;
   logic                      arb_data_valid;
   logic [DATA_W-1:0]         arb_data;
   logic [SRC_W-1:0]          arb_src_id;
   logic [CNT_W-1:0]          credit_cnt;
   logic                      busy;

   modport master (
      input  req_valid, req_last, req_data, fifo_out_valid,
      output req_ready, arb_data_valid, arb_data, arb_src_id, credit_cnt, busy
   );

   modport slave (
      output req_valid, req_last, req_data, fifo_out_valid,
      input  req_ready, arb_data_valid, arb_data, arb_src_id, credit_cnt, busy
   );
endinterface

// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin burst arbiter feeding the FIFO write port, with credit flow control from fifo_out_valid.
// Define ARB_FIXED_PRIO0_EN to let requester 0 pre-empt the round-robin choice whenever it is valid.
module fifo_rr_wr_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = 32,
   parameter int FIFO_DEPTH   = 8,
   parameter int MAX_BURST    = 4,
   parameter int IDLE_TIMEOUT = 8
) (
   input logic                    fifo_clk,
   input logic                    fifo_rst_n,
   fifo_rr_wr_arbiter_if.master   bus
);
   localparam int SRC_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [3:0]       BEAT_LAST  = 4'(MAX_BURST - 1);
   localparam logic [3:0]       STALL_LAST = 4'(IDLE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(FIFO_DEPTH);

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   state_t             state;
   logic [SRC_W-1:0]   grant_id;
   logic [SRC_W-1:0]   last_grant;
   logic [SRC_W-1:0]   next_grant;
   logic [3:0]         beat_cnt;
   logic [3:0]         stall_cnt;
   logic [CNT_W-1:0]   credit_cnt;
   logic [NUM_REQ-1:0] ready;
   logic               xfer;
   logic               sel_last;
   logic [DATA_W-1:0]  sel_data;
   logic               out_valid;
   logic [DATA_W-1:0]  out_data;
   logic [SRC_W-1:0]   out_src;

   // Search upward from the requester after last_grant, wrapping at NUM_REQ.
   always_comb begin
      int               idx;
      logic [SRC_W-1:0] cand;
      logic             found;
      // NOTE: every variable gets a default before any conditional write so no latch is inferred.
      next_grant = last_grant;
      found      = 1'b0;
      idx        = 0;
      cand       = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = int'(last_grant) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = SRC_W'(idx);
         if (!found && bus.req_valid[cand]) begin
            next_grant = cand;
            found      = 1'b1;
         end
      end
`ifdef ARB_FIXED_PRIO0_EN
      if (bus.req_valid[0]) next_grant = '0;
`endif
   end

   // Ready depends only on registered state, never on the producer's valid.
   always_comb begin
      ready = '0;
      if (state == BURST && credit_cnt != '0) ready[grant_id] = 1'b1;
   end

   assign xfer     = |(bus.req_valid & ready);
   assign sel_last = bus.req_last[grant_id];
   assign sel_data = bus.req_data[grant_id*DATA_W +: DATA_W];

   always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
      if (!fifo_rst_n) begin
         state      <= IDLE;
         grant_id   <= '0;
         last_grant <= SRC_W'(NUM_REQ - 1);
         beat_cnt   <= '0;
         stall_cnt  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         case (state)
            IDLE: begin
               if (|bus.req_valid) begin
                  grant_id  <= next_grant;
                  state     <= BURST;
                  beat_cnt  <= '0;
                  stall_cnt <= '0;
               end
            end
            BURST: begin
               if (xfer) begin
                  beat_cnt  <= beat_cnt + 4'd1;
                  stall_cnt <= '0;
                  if (sel_last || beat_cnt == BEAT_LAST) begin
                     state      <= IDLE;
                     last_grant <= grant_id;
                  end
               end else begin
                  // Credit stalls count here too, so a starved burst releases the port.
                  stall_cnt <= stall_cnt + 4'd1;
                  if (stall_cnt == STALL_LAST) begin
                     state      <= IDLE;
                     last_grant <= grant_id;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
      if (!fifo_rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
      end else begin
         out_valid <= xfer;
         if (xfer) begin
            out_data <= sel_data;
            out_src  <= grant_id;
         end
      end
   end

   // A simultaneous write and read leave the free-slot count unchanged.
   always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
      if (!fifo_rst_n) begin
         credit_cnt <= CREDIT_MAX;
      end else begin
         case ({xfer, bus.fifo_out_valid})
            2'b10:   credit_cnt <= credit_cnt - 1'b1;
            2'b01:   if (credit_cnt != CREDIT_MAX) credit_cnt <= credit_cnt + 1'b1;
            default: credit_cnt <= credit_cnt;
         endcase
      end
   end

   assign bus.req_ready      = ready;
   assign bus.arb_data_valid = out_valid;
   assign bus.arb_data       = out_data;
   assign bus.arb_src_id     = out_src;
   assign bus.credit_cnt     = credit_cnt;
   assign bus.busy           = (state == BURST);

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Directed bench for fifo_rr_wr_arbiter: producers are modelled per requester, expectations are hand-derived.
module tb_fifo_rr_wr_arbiter;
   localparam int NUM_REQ      = 4;
   localparam int DATA_W       = 32;
   localparam int FIFO_DEPTH   = 8;
   localparam int MAX_BURST    = 4;
   localparam int IDLE_TIMEOUT = 8;

   logic fifo_clk = 1'b0;
   logic fifo_rst_n;
   always #5 fifo_clk = ~fifo_clk;

   fifo_rr_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

   fifo_rr_wr_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
      .MAX_BURST(MAX_BURST), .IDLE_TIMEOUT(IDLE_TIMEOUT)
   ) u_dut (
      .fifo_clk   (fifo_clk),
      .fifo_rst_n (fifo_rst_n),
      .bus        (bus)
   );

   int passed = 0;
   int total  = 0;

   int                 beat_no [NUM_REQ];
   logic [DATA_W-1:0]  base    [NUM_REQ];
   logic [NUM_REQ-1:0] valid_mask;
   int                 last_after;

   task automatic drive_producers();
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_valid[i]                  = valid_mask[i];
         bus.req_data[i*DATA_W +: DATA_W]  = base[i] + DATA_W'(beat_no[i]);
         bus.req_last[i]                   = (last_after != 0) && ((beat_no[i] % last_after) == last_after - 1);
      end
   endtask

   // One clock: producers advance on the handshake seen just before the edge, outputs sampled 1 ns after.
   task automatic tick();
      logic [NUM_REQ-1:0] hs;
      hs = bus.req_valid & bus.req_ready;
      @(posedge fifo_clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) if (hs[i]) beat_no[i]++;
      drive_producers();
   endtask

   task automatic apply_reset();
      fifo_rst_n         = 1'b0;
      valid_mask         = '0;
      last_after         = 0;
      bus.fifo_out_valid = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         beat_no[i] = 0;
         base[i]    = 32'h1000 * (i + 1);
      end
      drive_producers();
      @(negedge fifo_clk);
      @(negedge fifo_clk);
      fifo_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (bus.credit_cnt !== 4'd8) $display("FAIL reset_credit: got %0d want 8", bus.credit_cnt); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
      total++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", bus.req_ready); else passed++;
      total++; if (bus.arb_data_valid !== 1'b0 || bus.arb_data !== 32'h0 || bus.arb_src_id !== 2'd0)
         $display("FAIL reset_outputs: got v=%b d=%h s=%0d want 0/0/0", bus.arb_data_valid, bus.arb_data, bus.arb_src_id);
      else passed++;
   endtask

   // All four request, two-beat bursts, reads keep credits topped up.
   task automatic test_round_robin();
      int   exp_v [14] = '{0,1,1,0,1,1,0,1,1,0,1,1,0,1};
      int   exp_s [14] = '{0,0,0,0,1,1,0,2,2,0,3,3,0,0};
      int   exp_b [14] = '{1,1,0,1,1,0,1,1,0,1,1,0,1,1};
      int   seen  [NUM_REQ];
      logic [DATA_W-1:0] exp_d;
      apply_reset();
      for (int i = 0; i < NUM_REQ; i++) seen[i] = 0;
      valid_mask         = 4'b1111;
      last_after         = 2;
      bus.fifo_out_valid = 1'b1;
      drive_producers();
      for (int k = 0; k < 14; k++) begin
         tick();
         exp_d = base[exp_s[k]] + DATA_W'(seen[exp_s[k]]);
         total++;
         if (bus.arb_data_valid !== exp_v[k][0] || bus.busy !== exp_b[k][0] ||
             (exp_v[k] == 1 && (bus.arb_src_id !== 2'(exp_s[k]) || bus.arb_data !== exp_d)))
            $display("FAIL rr_cycle%0d: got v=%b s=%0d d=%h busy=%b want v=%0d s=%0d d=%h busy=%0d",
                     k + 1, bus.arb_data_valid, bus.arb_src_id, bus.arb_data, bus.busy, exp_v[k], exp_s[k], exp_d, exp_b[k]);
         else passed++;
         if (exp_v[k] == 1) seen[exp_s[k]]++;
      end
      total++; if (bus.credit_cnt !== 4'd8) $display("FAIL rr_credit: got %0d want 8", bus.credit_cnt); else passed++;
   endtask

   // Requester 2 alone, never signals last, no reads: max-burst split then credit exhaustion.
   task automatic test_max_burst_credits();
      apply_reset();
      valid_mask = 4'b0100;
      base[2]    = 32'hA0;
      drive_producers();
      repeat (2) tick();
      total++; if (bus.arb_data_valid !== 1'b1 || bus.arb_data !== 32'hA0 || bus.arb_src_id !== 2'd2)
         $display("FAIL mb_first: got v=%b d=%h s=%0d want 1/a0/2", bus.arb_data_valid, bus.arb_data, bus.arb_src_id);
      else passed++;
      repeat (3) tick();
      total++; if (bus.arb_data !== 32'hA3 || bus.credit_cnt !== 4'd4 || bus.busy !== 1'b0)
         $display("FAIL mb_fourth: got d=%h credit=%0d busy=%b want a3/4/0", bus.arb_data, bus.credit_cnt, bus.busy);
      else passed++;
      tick();
      total++; if (bus.busy !== 1'b1 || bus.arb_data_valid !== 1'b0 || bus.req_ready !== 4'b0100)
         $display("FAIL mb_regrant: got busy=%b v=%b ready=%b want 1/0/0100", bus.busy, bus.arb_data_valid, bus.req_ready);
      else passed++;
      tick();
      total++; if (bus.arb_data !== 32'hA4 || bus.arb_src_id !== 2'd2)
         $display("FAIL mb_fifth: got d=%h s=%0d want a4/2", bus.arb_data, bus.arb_src_id);
      else passed++;
      repeat (3) tick();
      total++; if (bus.credit_cnt !== 4'd0 || bus.arb_data !== 32'hA7)
         $display("FAIL mb_credit0: got credit=%0d d=%h want 0/a7", bus.credit_cnt, bus.arb_data);
      else passed++;
      tick();
      total++; if (bus.busy !== 1'b1 || bus.req_ready !== 4'b0000)
         $display("FAIL mb_ready_gated: got busy=%b ready=%b want 1/0000", bus.busy, bus.req_ready);
      else passed++;
   endtask

   // Exhaust credits on requester 1, then return exactly one credit.
   task automatic test_credit_return();
      apply_reset();
      valid_mask = 4'b0010;
      drive_producers();
      repeat (11) tick();
      total++; if (bus.credit_cnt !== 4'd0 || bus.req_ready !== 4'b0000 || bus.busy !== 1'b1)
         $display("FAIL cr_starved: got credit=%0d ready=%b busy=%b want 0/0000/1", bus.credit_cnt, bus.req_ready, bus.busy);
      else passed++;
      bus.fifo_out_valid = 1'b1;
      tick();
      bus.fifo_out_valid = 1'b0;
      total++; if (bus.credit_cnt !== 4'd1 || bus.req_ready !== 4'b0010 || bus.arb_data_valid !== 1'b0)
         $display("FAIL cr_one_credit: got credit=%0d ready=%b v=%b want 1/0010/0", bus.credit_cnt, bus.req_ready, bus.arb_data_valid);
      else passed++;
      tick();
      total++; if (bus.arb_data_valid !== 1'b1 || bus.arb_src_id !== 2'd1 || bus.arb_data !== 32'h2008 || bus.credit_cnt !== 4'd0)
         $display("FAIL cr_one_beat: got v=%b s=%0d d=%h credit=%0d want 1/1/2008/0", bus.arb_data_valid, bus.arb_src_id, bus.arb_data, bus.credit_cnt);
      else passed++;
      tick();
      total++; if (bus.arb_data_valid !== 1'b0 || bus.req_ready !== 4'b0000)
         $display("FAIL cr_after: got v=%b ready=%b want 0/0000", bus.arb_data_valid, bus.req_ready);
      else passed++;
   endtask

   task automatic test_credit_same_cycle();
      apply_reset();
      bus.fifo_out_valid = 1'b1;
      repeat (2) tick();
      total++; if (bus.credit_cnt !== 4'd8) $display("FAIL cs_saturate: got %0d want 8", bus.credit_cnt); else passed++;
      bus.fifo_out_valid = 1'b0;
      valid_mask = 4'b0001;
      drive_producers();
      repeat (7) tick();
      total++; if (bus.credit_cnt !== 4'd3) $display("FAIL cs_setup: got %0d want 3", bus.credit_cnt); else passed++;
      bus.fifo_out_valid = 1'b1;
      tick();
      bus.fifo_out_valid = 1'b0;
      total++; if (bus.credit_cnt !== 4'd3 || bus.arb_data_valid !== 1'b1 || bus.arb_data !== 32'h1005)
         $display("FAIL cs_both: got credit=%0d v=%b d=%h want 3/1/1005", bus.credit_cnt, bus.arb_data_valid, bus.arb_data);
      else passed++;
   endtask

   // Requester 3 goes silent; the grant times out and pending requester 0 is served next.
   task automatic test_idle_timeout();
      apply_reset();
      valid_mask = 4'b1000;
      drive_producers();
      tick();
      total++; if (bus.busy !== 1'b1 || bus.req_ready !== 4'b1000)
         $display("FAIL to_grant3: got busy=%b ready=%b want 1/1000", bus.busy, bus.req_ready);
      else passed++;
      valid_mask = 4'b0001;
      drive_producers();
      repeat (7) tick();
      total++; if (bus.busy !== 1'b1) $display("FAIL to_still_busy: got %b want 1", bus.busy); else passed++;
      tick();
      total++; if (bus.busy !== 1'b0) $display("FAIL to_released: got %b want 0", bus.busy); else passed++;
      tick();
      total++; if (bus.busy !== 1'b1 || bus.req_ready !== 4'b0001)
         $display("FAIL to_grant0: got busy=%b ready=%b want 1/0001", bus.busy, bus.req_ready);
      else passed++;
      tick();
      total++; if (bus.arb_data_valid !== 1'b1 || bus.arb_src_id !== 2'd0)
         $display("FAIL to_beat0: got v=%b s=%0d want 1/0", bus.arb_data_valid, bus.arb_src_id);
      else passed++;
   endtask

   task automatic test_reset_mid_burst();
      apply_reset();
      valid_mask = 4'b0001;
      drive_producers();
      repeat (3) tick();
      total++; if (bus.arb_data_valid !== 1'b1 || bus.credit_cnt !== 4'd6)
         $display("FAIL rm_setup: got v=%b credit=%0d want 1/6", bus.arb_data_valid, bus.credit_cnt);
      else passed++;
      #2 fifo_rst_n = 1'b0;
      #1;
      total++; if (bus.arb_data_valid !== 1'b0 || bus.arb_data !== 32'h0 || bus.credit_cnt !== 4'd8 ||
                   bus.busy !== 1'b0 || bus.req_ready !== 4'b0000)
         $display("FAIL rm_async: got v=%b d=%h credit=%0d busy=%b ready=%b want 0/0/8/0/0000",
                  bus.arb_data_valid, bus.arb_data, bus.credit_cnt, bus.busy, bus.req_ready);
      else passed++;
      @(negedge fifo_clk);
      fifo_rst_n = 1'b1;
   endtask

   // Requesters 0,1,3 with single-beat bursts; requester 0 wins every time when fixed priority is built in.
   task automatic test_prio_1011();
`ifdef ARB_FIXED_PRIO0_EN
      int exp_s [4] = '{0,0,0,0};
`else
      int exp_s [4] = '{0,1,3,0};
`endif
      apply_reset();
      valid_mask         = 4'b1011;
      last_after         = 1;
      bus.fifo_out_valid = 1'b1;
      drive_producers();
      for (int n = 0; n < 4; n++) begin
         repeat (2) tick();
         total++; if (bus.arb_data_valid !== 1'b1 || bus.arb_src_id !== 2'(exp_s[n]))
            $display("FAIL prio_grant%0d: got v=%b s=%0d want 1/%0d", n, bus.arb_data_valid, bus.arb_src_id, exp_s[n]);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
`ifndef ARB_FIXED_PRIO0_EN
      test_round_robin();
`endif
      test_max_burst_credits();
      test_credit_return();
      test_credit_same_cycle();
      test_idle_timeout();
      test_reset_mid_burst();
      test_prio_1011();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
